// File: rtl/romulus_key_pkg.sv
// Shared definitions for the DOM-protected Romulus-N key path controllers.
package romulus_key_pkg;

    // Key serial-to-parallel controller states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_READY     = 3'd2,
        ST_RUN       = 3'd3,
        ST_WAIT_CRCT = 3'd4
    } key_state_e;

    localparam int unsigned D_DEFAULT      = 2;
    localparam int unsigned ROUNDS_DEFAULT = 40;

    // Number of 32-bit sdi words that fill a 128*d bit share buffer.
    function automatic int unsigned n_words(input int unsigned d);
        return 4 * d;
    endfunction

    // Word counter width: log2 of the word count (at least 1 bit).
    function automatic int unsigned wcnt_width(input int unsigned d);
        return (n_words(d) > 1) ? $clog2(n_words(d)) : 1;
    endfunction

    // Round counter width: ceil(log2 rounds) (at least 1 bit).
    function automatic int unsigned rcnt_width(input int unsigned rounds);
        return (rounds > 1) ? $clog2(rounds) : 1;
    endfunction

    localparam int unsigned WCNT_W_DEFAULT = wcnt_width(D_DEFAULT);
    localparam int unsigned RCNT_W_DEFAULT = rcnt_width(ROUNDS_DEFAULT);

endpackage

// File: rtl/key_serpar_ctrl.sv
// Sequencer for the key share serial-to-parallel buffer: loads 4*D sdi
// words, steps the buffer once per cipher round, then waits for the mode
// controller to supply a corrected key before the key can be reused.
module key_serpar_ctrl
    import romulus_key_pkg::*;
#(
    parameter int unsigned D      = D_DEFAULT,
    parameter int unsigned ROUNDS = ROUNDS_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_start,
    input  logic sdi_valid,
    output logic sdi_ready,
    input  logic run_start,
    input  logic crct_req,
    output logic key_wr,
    output logic key_en,
    output logic key_crct,
    output logic key_ready,
    output logic run_done,
    output logic busy
);

    localparam int unsigned N_WORDS = n_words(D);
    localparam int unsigned WCNT_W  = wcnt_width(D);
    localparam int unsigned RCNT_W  = rcnt_width(ROUNDS);

    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(N_WORDS - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(ROUNDS - 1);
    localparam logic [RCNT_W-1:0] RCNT_ONE  = RCNT_W'(1);

    key_state_e        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q,  wcnt_d;
    logic [RCNT_W-1:0] rcnt_q,  rcnt_d;

    // Next-state, counter and strobe decode; strobes are purely combinational.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        sdi_ready = 1'b0;
        key_wr    = 1'b0;
        key_en    = 1'b0;
        key_crct  = 1'b0;
        key_ready = 1'b0;
        run_done  = 1'b0;
        busy      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_start) begin
                    state_d = ST_LOAD;
                    wcnt_d  = '0;
                end
            end

            ST_LOAD: begin
                sdi_ready = 1'b1;
                key_wr    = sdi_valid;
                busy      = 1'b1;
                // A restart still shifts any word on the bus; the new load
                // simply overwrites it, so only the counter needs clearing.
                if (key_start) begin
                    wcnt_d = '0;
                end else if (sdi_valid) begin
                    if (wcnt_q == WCNT_LAST) begin
                        state_d = ST_READY;
                        wcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_ONE;
                    end
                end
            end

            ST_READY: begin
                key_ready = 1'b1;
                if (key_start) begin
                    state_d = ST_LOAD;
                    wcnt_d  = '0;
                end else if (run_start) begin
                    state_d = ST_RUN;
                    rcnt_d  = '0;
                end else if (crct_req) begin
                    key_crct = 1'b1;
                end
            end

            ST_RUN: begin
                key_en = 1'b1;
                busy   = 1'b1;
                if (rcnt_q == RCNT_LAST) begin
                    run_done = 1'b1;
                    state_d  = ST_WAIT_CRCT;
                    rcnt_d   = '0;
                end else begin
                    rcnt_d = rcnt_q + RCNT_ONE;
                end
            end

            ST_WAIT_CRCT: begin
                busy = 1'b1;
                if (key_start) begin
                    state_d = ST_LOAD;
                    wcnt_d  = '0;
                end else if (crct_req) begin
                    key_crct = 1'b1;
                    state_d  = ST_READY;
                end
            end

            default: begin
                state_d = ST_IDLE;
                wcnt_d  = '0;
                rcnt_d  = '0;
            end
        endcase
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

endmodule
